// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   32 x 32-bit architectural register file with a per-register busy
//   scoreboard. Decode reads two operands combinationally and gets a hazard
//   flag while an operand still has an unretired writer. Issue marks the
//   destination busy. Write-back stores the result and clears the busy bit.
//
//   Optional feature: define WB_BYPASS_EN to forward write-back data to the
//   read ports in the write cycle and mask the matching pending bit.
//
// Ports
//   CLK          clock, all state updates on posedge
//   RST_N        asynchronous active-low reset (registers and busy bits -> 0)
//   rs1_en       decode uses rs1 this cycle
//   rs1_addr     rs1 index
//   rs1_data     rs1 value (combinational)
//   rs2_en       decode uses rs2 this cycle
//   rs2_addr     rs2 index
//   rs2_data     rs2 value (combinational)
//   hazard       an enabled operand is pending; decode must stall
//   issue_valid  decode issues an instruction writing issue_rd
//   issue_rd     destination of the issued instruction
//   issue_ack    issue accepted this cycle (issue_valid & ~hazard)
//   we           write-back enable
//   wr_addr      write-back destination
//   wr_data      write-back data
//   flush        clears every busy bit and drops a same-cycle issue
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            rs1_en,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic            rs2_en,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            hazard,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ack,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            flush
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    logic wr_live;
    logic rs1_pend;
    logic rs2_pend;

    // x0 is never a write target, so a write to it is not "live".
    assign wr_live = we && (wr_addr != '0);

`ifdef WB_BYPASS_EN
    logic rs1_byp;
    logic rs2_byp;

    assign rs1_byp = wr_live && (wr_addr == rs1_addr);
    assign rs2_byp = wr_live && (wr_addr == rs2_addr);

    // Forwarded operands are usable now, so their busy bit is ignored.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) rs1_data = rs1_byp ? wr_data : regs[rs1_addr];
        if (rs2_addr != '0) rs2_data = rs2_byp ? wr_data : regs[rs2_addr];
    end

    assign rs1_pend = busy[rs1_addr] && (rs1_addr != '0) && !rs1_byp;
    assign rs2_pend = busy[rs2_addr] && (rs2_addr != '0) && !rs2_byp;
`else
    // Without forwarding the old value is shown during the write cycle and
    // the busy bit only drops at the following posedge.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) rs1_data = regs[rs1_addr];
        if (rs2_addr != '0) rs2_data = regs[rs2_addr];
    end

    assign rs1_pend = busy[rs1_addr] && (rs1_addr != '0);
    assign rs2_pend = busy[rs2_addr] && (rs2_addr != '0);
`endif

    assign hazard    = (rs1_en && rs1_pend) || (rs2_en && rs2_pend);
    assign issue_ack = issue_valid && !hazard;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Priority: flush, then issue set, then write-back clear. The issue
    // assignment comes last so it overrides a clear of the same register,
    // recording the newer writer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (wr_live) busy[wr_addr] <= 1'b0;
            if (issue_ack && (issue_rd != '0)) busy[issue_rd] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic        CLK;
    logic        RST_N;
    logic        rs1_en;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic        rs2_en;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic        hazard;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ack;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        flush;

    int total = 0;
    int bad   = 0;

    regfile_scoreboard #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .rs1_en(rs1_en), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .rs2_en(rs2_en), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .hazard(hazard),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ack(issue_ack),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic bit fwd(input logic [4:0] a);
        return BYP && we && (wr_addr != 0) && (wr_addr == a);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (fwd(a)) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit m_pend(input logic [4:0] a);
        return (a != 0) && m_busy[a] && !fwd(a);
    endfunction

    function automatic bit m_hazard();
        return (rs1_en && m_pend(rs1_addr)) || (rs2_en && m_pend(rs2_addr));
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'h0;
                m_busy[r] = 1'b0;
            end
        end else begin
            bit ack;
            ack = issue_valid && !m_hazard();
            if (we && wr_addr != 0) m_regs[wr_addr] = wr_data;
            for (int r = 0; r < 32; r++) begin
                if (flush)                                m_busy[r] = 1'b0;
                else if (ack && issue_rd != 0 && r == issue_rd) m_busy[r] = 1'b1;
                else if (we && wr_addr != 0 && r == wr_addr)    m_busy[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        check("cmp_rs1_data", rs1_data, m_read(rs1_addr));
        check("cmp_rs2_data", rs2_data, m_read(rs2_addr));
        check("cmp_hazard", {31'b0, hazard}, {31'b0, m_hazard()});
        check("cmp_issue_ack", {31'b0, issue_ack}, {31'b0, issue_valid && !m_hazard()});
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        rs1_en = 0; rs1_addr = 0; rs2_en = 0; rs2_addr = 0;
        issue_valid = 0; issue_rd = 0; we = 0; wr_addr = 0; wr_data = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0;
        idle();
        #1;
        // 1. reset: every address reads zero, no hazard
        rs1_en = 1; rs2_en = 1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
            #1;
            if (rs1_data != 0 || rs2_data != 0 || hazard != 0) begin
                check("reset_read", {rs1_data | rs2_data}, 32'h0);
                check("reset_hazard", {31'b0, hazard}, 32'h0);
            end
        end
        check("reset_rs1", rs1_data, 32'h0);
        check("reset_ack", {31'b0, issue_ack}, 32'h0);
        idle();
        @(negedge CLK);
        #2 RST_N = 1'b1;
        tick();

        // 2. write and read back; x0 write ignored
        we = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        tick();
        idle(); rs1_en = 1; rs1_addr = 5;
        #2 check("rd_x5", rs1_data, 32'hDEADBEEF);
        we = 1; wr_addr = 0; wr_data = 32'h1234;
        tick();
        idle(); rs1_en = 1; rs1_addr = 0;
        #2 check("rd_x0", rs1_data, 32'h0);

        // 3. scoreboard on x7
        idle(); issue_valid = 1; issue_rd = 7;
        #2 check("issue7_ack", {31'b0, issue_ack}, 32'h1);
        tick();
        issue_valid = 1; issue_rd = 11; rs2_en = 1; rs2_addr = 7;
        #2 check("x7_hazard", {31'b0, hazard}, 32'h1);
        check("x7_ack_blocked", {31'b0, issue_ack}, 32'h0);
        tick();
        issue_valid = 0; we = 1; wr_addr = 7; wr_data = 32'h55;
        #2 check("x7_wb_hazard", {31'b0, hazard}, BYP ? 32'h0 : 32'h1);
        check("x7_wb_data", rs2_data, BYP ? 32'h55 : 32'h0);
        tick();
        we = 0; rs1_en = 1; rs1_addr = 11;
        #2 check("x7_after_hazard", {31'b0, hazard}, 32'h0);
        check("x7_after_data", rs2_data, 32'h55);

        // 4. issue and write-back of x9 in the same cycle
        idle(); issue_valid = 1; issue_rd = 9; we = 1; wr_addr = 9; wr_data = 32'h99;
        tick();
        idle(); rs1_addr = 9;
        #2 check("x9_disabled_hazard", {31'b0, hazard}, 32'h0);
        check("x9_data", rs1_data, 32'h99);
        rs1_en = 1;
        #1 check("x9_busy", {31'b0, hazard}, 32'h1);
        tick();
        idle(); we = 1; wr_addr = 9; wr_data = 32'h9A;
        tick();

        // 5. flush with busy 3, 4, 10 plus concurrent issue of 12
        idle(); issue_valid = 1; issue_rd = 3; tick();
        issue_rd = 4; tick();
        issue_rd = 10; tick();
        issue_rd = 12; flush = 1;
        #2 check("flush_ack_reported", {31'b0, issue_ack}, 32'h1);
        tick();
        idle(); rs1_en = 1; rs2_en = 1;
        rs1_addr = 3; rs2_addr = 12;
        #1 check("flush_3_12", {31'b0, hazard}, 32'h0);
        rs1_addr = 4; rs2_addr = 10;
        #1 check("flush_4_10", {31'b0, hazard}, 32'h0);
        tick();
        idle(); we = 1; wr_addr = 3; wr_data = 32'hA5;
        tick();
        idle(); rs1_addr = 3;
        #2 check("late_wb_x3", rs1_data, 32'hA5);

        // 6. asynchronous reset while x8 is busy and holds FF
        idle(); issue_valid = 1; issue_rd = 8; we = 1; wr_addr = 8; wr_data = 32'hFF;
        tick();
        idle(); rs1_en = 1; rs1_addr = 8;
        #2 check("x8_busy", {31'b0, hazard}, 32'h1);
        check("x8_data", rs1_data, 32'hFF);
        #1 RST_N = 1'b0;
        #1 check("async_rst_data", rs1_data, 32'h0);
        check("async_rst_hazard", {31'b0, hazard}, 32'h0);
        @(posedge CLK);
        #3 RST_N = 1'b1;
        tick();
        #1 check("x8_busy_after_rst", {31'b0, hazard}, 32'h0);
        check("x8_data_after_rst", rs1_data, 32'h0);

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
